// File: rtl/npower_imm_pkg.sv
// npower_imm_pkg: nPower immediate opcode map, form tags and the immediate decode function
package npower_imm_pkg;
  localparam int MAX_XLEN = 64;
  localparam logic [5:0] OPC_D_1F = 6'b011111;
  localparam logic [5:0] OPC_D_0E = 6'b001110;
  localparam logic [5:0] OPC_D_1C = 6'b011100;
  localparam logic [5:0] OPC_D_18 = 6'b011000;
  localparam logic [5:0] OPC_DS_3A = 6'b111010;
  localparam logic [5:0] OPC_DS_3E = 6'b111110;
  localparam logic [5:0] OPC_DS_13 = 6'b010011;
  localparam logic [5:0] OPC_DSH_0F = 6'b001111;
  localparam logic [5:0] OPC_DZ_19 = 6'b011001;
  typedef enum logic [2:0] {FORM_NONE, FORM_D, FORM_DS, FORM_DSH, FORM_DZ} imm_form_e;
  typedef struct packed {
    imm_form_e form;
    logic illegal;
    logic [MAX_XLEN-1:0] imm;
  } imm_dec_t;
  function automatic imm_dec_t imm_decode(input logic [31:0] instr, input logic en_sh, input logic en_z);
    imm_dec_t d;
    d = '{form: FORM_NONE, illegal: 1'b1, imm: '0};
    case (instr[5:0])
      OPC_D_1F, OPC_D_0E, OPC_D_1C, OPC_D_18:
        d = '{form: FORM_D, illegal: 1'b0, imm: {{48{instr[31]}}, instr[31:16]}};
      OPC_DS_3A, OPC_DS_3E, OPC_DS_13:
        d = '{form: FORM_DS, illegal: 1'b0, imm: {{48{instr[31]}}, instr[31:18], 2'b00}};
      OPC_DSH_0F:
        if (en_sh) d = '{form: FORM_DSH, illegal: 1'b0, imm: {{32{instr[31]}}, instr[31:16], 16'h0000}};
      OPC_DZ_19:
        if (en_z) d = '{form: FORM_DZ, illegal: 1'b0, imm: {48'h0, instr[31:16]}};
      default: ;
    endcase
    return d;
  endfunction
endpackage

// File: rtl/imm_skid_buf.sv
// imm_skid_buf: 2-entry valid/ready register slice (main + skid); ports clk, rst_n, in_valid/in_ready/in_data, out_valid/out_ready/out_data
module imm_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         acc_in;
  logic         pop;
  logic         skid_nxt;
  assign acc_in   = in_valid & in_ready;
  assign pop      = !out_valid | out_ready;
  assign skid_nxt = pop ? 1'b0 : (skid_valid | acc_in);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      in_ready   <= 1'b0;
    end else begin
      in_ready   <= !skid_nxt;
      skid_valid <= skid_nxt;
      if (pop) begin
        out_valid <= skid_valid | acc_in;
        if (skid_valid) out_data <= skid_data;
        else if (acc_in) out_data <= in_data;
      end else if (acc_in) begin
        skid_data <= in_data;
      end
    end
  end
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered nPower immediate generator; in_valid/in_ready/in_instr in, out_valid/out_ready/out_imm/out_form/out_illegal out
module imm_gen_pipe
  import npower_imm_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter bit EN_SHIFTED = 1'b1,
  parameter bit EN_ZEXT    = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output imm_form_e       out_form,
  output logic            out_illegal
);
  imm_dec_t        dec;
  logic [XLEN+3:0] q;
  assign dec = imm_decode(in_instr, EN_SHIFTED, EN_ZEXT);
  imm_skid_buf #(.W(XLEN + 4)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  ({dec.form, dec.illegal, dec.imm[XLEN-1:0]}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (q)
  );
  assign out_imm     = q[XLEN-1:0];
  assign out_illegal = q[XLEN];
  assign out_form    = imm_form_e'(q[XLEN+3:XLEN+1]);
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: scoreboard bench for imm_gen_pipe at XLEN=64 and at XLEN=32 with zero-extended-D disabled
module tb_imm_gen_pipe;
  import npower_imm_pkg::*;
  logic clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic in_ready_a, out_valid_a, out_illegal_a, in_ready_b, out_valid_b, out_illegal_b;
  logic [63:0] out_imm_a;
  logic [31:0] out_imm_b;
  imm_form_e out_form_a, out_form_b;
  int errors = 0, checks = 0;
  typedef struct packed {logic [63:0] imm; logic [2:0] form; logic ill;} exp_t;
  exp_t qa[$], qb[$];
  exp_t ea, eb;
  logic [31:0] v_in [12] = '{32'h8000_03CE, 32'h8007_003A, 32'h1234_000F, 32'h8000_000F,
                             32'hFFFF_0019, 32'hABCD_0000, 32'hFFFE_001F, 32'h7FFF_001C,
                             32'h1235_003E, 32'hFFFF_0013, 32'h0001_0018, 32'h1234_003F};
  logic [63:0] v64 [12] = '{64'hFFFF_FFFF_FFFF_8000, 64'hFFFF_FFFF_FFFF_8004, 64'h0000_0000_1234_0000,
                            64'hFFFF_FFFF_8000_0000, 64'h0000_0000_0000_FFFF, 64'h0,
                            64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_7FFF, 64'h0000_0000_0000_1234,
                            64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_0000_0000_0001, 64'h0};
  imm_form_e f64 [12] = '{FORM_D, FORM_DS, FORM_DSH, FORM_DSH, FORM_DZ, FORM_NONE,
                          FORM_D, FORM_D, FORM_DS, FORM_DS, FORM_D, FORM_NONE};
  logic il64 [12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
  logic [31:0] v32 [12] = '{32'hFFFF_8000, 32'hFFFF_8004, 32'h1234_0000, 32'h8000_0000,
                            32'h0, 32'h0, 32'hFFFF_FFFE, 32'h0000_7FFF,
                            32'h0000_1234, 32'hFFFF_FFFC, 32'h0000_0001, 32'h0};
  imm_form_e f32 [12] = '{FORM_D, FORM_DS, FORM_DSH, FORM_DSH, FORM_NONE, FORM_NONE,
                          FORM_D, FORM_D, FORM_DS, FORM_DS, FORM_D, FORM_NONE};
  logic il32 [12] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1};

  imm_gen_pipe #(.XLEN(64)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a), .in_instr(in_instr),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_imm(out_imm_a), .out_form(out_form_a),
    .out_illegal(out_illegal_a)
  );
  imm_gen_pipe #(.XLEN(32), .EN_SHIFTED(1'b1), .EN_ZEXT(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b), .in_instr(in_instr),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_imm(out_imm_b), .out_form(out_form_b),
    .out_illegal(out_illegal_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic push(input int i);
    qa.push_back('{v64[i], f64[i], il64[i]});
    qb.push_back('{{32'h0, v32[i]}, f32[i], il32[i]});
  endtask

  task automatic stream(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      in_valid = 1'b1;
      in_instr = v_in[i];
      chk("stream_in_ready", {in_ready_a, in_ready_b}, 2'b11);
      if (in_ready_a) push(i);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", 68'(qa.size() + qb.size()), 68'h0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid_a && out_ready) begin
      if (qa.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL a_unexpected_out: got imm %h with nothing expected", out_imm_a);
      end else begin
        ea = qa.pop_front();
        chk("a_out", {out_imm_a, out_form_a, out_illegal_a}, ea);
      end
    end
    if (rst_n && out_valid_b && out_ready) begin
      if (qb.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL b_unexpected_out: got imm %h with nothing expected", out_imm_b);
      end else begin
        eb = qb.pop_front();
        chk("b_out", {32'h0, out_imm_b, out_form_b, out_illegal_b}, eb);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, j;
    #1 rst_n = 1'b0;
    #6;
    chk("reset_in_ready", {in_ready_a, in_ready_b}, 2'b00);
    chk("reset_out_valid", {out_valid_a, out_valid_b}, 2'b00);
    #15 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_in_ready", {in_ready_a, in_ready_b}, 2'b11);
    chk("reset_outputs", {out_valid_a, out_imm_a, out_form_a, out_illegal_a}, 68'h0);
    out_ready = 1'b1;
    stream(0, 11);
    drain();
    out_ready = 1'b0;
    acc = 0;
    j = 0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_instr = v_in[j];
      if (in_ready_a) begin
        push(j);
        acc++;
        j++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("bp_accepted", 68'(acc), 68'd2);
    chk("bp_in_ready_low", {in_ready_a, in_ready_b}, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_hold", {out_valid_a, out_imm_a}, {1'b1, v64[0]});
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_ready", {in_ready_a, in_ready_b}, 2'b11);
    stream(4, 11);
    drain();
    out_ready = 1'b0;
    stream(2, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_clear", {out_valid_a, out_valid_b, in_ready_a, out_imm_a, out_form_a}, 70'h0);
    qa.delete();
    qb.delete();
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_release_ready", {in_ready_a, in_ready_b}, 2'b11);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("no_stale_out", {out_valid_a, out_valid_b}, 2'b00);
    stream(9, 11);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parameterised, registered immediate generator for the nPower decode stage.
- Accepts one 32-bit instruction per valid/ready handshake and classifies it by the opcode field instruction[5:0].
- Produces an XLEN-wide immediate plus a form tag and an illegal flag, with full backpressure support.
- Sits between fetch/decode and the register-read stage. Replaces the combinational sign-extender; every output is registered and no output is ever latched.

Parameters:
- XLEN, 64, output immediate width; legal values are 32 and 64.
- EN_SHIFTED, 1, enables shifted-D decoding; when 0, the shifted-D opcode is classed illegal.
- EN_ZEXT, 1, enables zero-extended-D decoding; when 0, the zero-extended-D opcode is classed illegal.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction valid.
- in_ready  out  1  block can accept an instruction.
- in_instr  in  32  instruction word; opcode field is in_instr[5:0].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_imm  out  XLEN  generated immediate.
- out_form  out  3  form tag (package enum).
- out_illegal  out  1  opcode has no immediate form.

Behaviour:
- Reset: asserting rst_n low at any time, including mid-transfer, clears immediately: out_valid=0, out_imm=0, out_form=FORM_NONE, out_illegal=0, skid buffer empty. While in reset, in_ready=0; in_ready=1 on the first cycle after reset release.
- Opcode classes (values of in_instr[5:0]):
  - D_SIGNED: 6'b011111, 6'b001110, 6'b011100, 6'b011000. Result = sign-extend(in_instr[31:16]).
  - DS: 6'b111010, 6'b111110, 6'b010011. Result = sign-extend({in_instr[31:18], 2'b00}).
  - D_SHIFTED: 6'b001111. Result = sign-extend({in_instr[31:16], 16'h0000}); for XLEN=32 the raw concatenation is used as-is.
  - D_ZEXT: 6'b011001. Result = zero-extend(in_instr[31:16]).
  - Any other opcode, or a disabled class: out_imm=0, out_form=FORM_NONE, out_illegal=1. This is not an error stop; the transfer completes normally.
- Handshake:
  - A transfer occurs on a rising edge where valid & ready.
  - Latency is 1 cycle: an instruction accepted at edge N appears on out_* after edge N.
  - A 2-deep output stage (main register plus skid register) gives full throughput of 1 per cycle with out_ready held high.
  - in_ready = !skid_full; it is registered and does not depend combinationally on out_ready.
- Backpressure:
  - If out_valid & !out_ready and a new instruction is accepted, that instruction goes to the skid register and in_ready drops on the next cycle.
  - When out_ready rises, the main register takes the skid entry on that edge and in_ready returns to 1.
  - out_* stay stable while out_valid & !out_ready.
- Simultaneous events: an edge with an input accept plus an output accept and an empty skid reloads the main register directly. There are no bubbles and no duplicates. Order is strict FIFO.
- Empty: out_valid=0; out_imm keeps its last value (don't-care).
- Width: all extension is done at XLEN. There is no intermediate 32-bit stage.

Decomposition:
- Package npower_imm_pkg holds:
  - the opcode localparams (OPC_* for each value above);
  - enum imm_form_e {FORM_NONE, FORM_D, FORM_DS, FORM_DSH, FORM_DZ};
  - function imm_decode(instr) returning {form, illegal, imm}, parameterised by XLEN via its argument width.
- Sub-module imm_skid_buf: the generic 2-entry valid/ready register slice, reusable elsewhere in the pipeline. The top level is the decode function plus one imm_skid_buf instance.

Test Plan:
- XLEN=64, opcode 6'b001110, in_instr[31:16]=16'h8000 -> out_imm=64'hFFFF_FFFF_FFFF_8000, out_form=FORM_D, out_illegal=0, one cycle after the accept.
- Opcode 6'b111010, in_instr[31:18]=14'h2001 -> out_imm=64'hFFFF_FFFF_FFFF_8004, FORM_DS. Opcode 6'b001111, [31:16]=16'h1234 -> 64'h0000_0000_1234_0000; [31:16]=16'h8000 -> 64'hFFFF_FFFF_8000_0000.
- Opcode 6'b011001, [31:16]=16'hFFFF -> 64'h0000_0000_0000_FFFF. Opcode 6'b000000 -> out_imm=0, out_illegal=1. With EN_ZEXT=0, opcode 6'b011001 -> illegal.
- Backpressure: stream 4 instructions with out_ready=0 -> exactly 2 accepted, then in_ready=0. Raise out_ready -> all outputs arrive in order, then throughput returns to 1 per cycle with no loss or duplication.
- Reset mid-operation: assert rst_n=0 with both entries full -> out_valid=0 immediately without waiting for a clock edge. After release, in_ready=1 and no stale result is emitted.
- XLEN=32, opcode 6'b011111, [31:16]=16'hFFFE -> out_imm=32'hFFFF_FFFE.
